// File: rtl/packet_deframer_pkg.sv
// Shared types and helpers for the packet deframer: header byte, command, error and state encodings.
package pkt_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hF5;

  typedef enum logic [7:0] {
    CMD_NOP        = 8'h00,
    CMD_PROG       = 8'h01,
    CMD_ENTER_SYM  = 8'h02,
    CMD_SYM        = 8'h03,
    CMD_ENTER_PROG = 8'h04
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_RX       = 3'd1,
    ERR_BAD_CMD  = 3'd2,
    ERR_CSUM     = 3'd3,
    ERR_TIMEOUT  = 3'd4,
    ERR_OVERFLOW = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    CHECKSUM,
    OUTPUT
  } state_e;

  function automatic int cmd_len(input logic [7:0] cmd, input int prog_len, input int sym_len);
    int len;
    len = 0;
    if (cmd == CMD_PROG)
      len = prog_len;
    else if (cmd == CMD_SYM)
      len = sym_len;
    return len;
  endfunction

  // PROG is only accepted in program mode and SYM only in symbol mode.
  function automatic logic cmd_legal(input logic [7:0] cmd, input logic prog_mode);
    logic ok;
    case (cmd)
      CMD_NOP, CMD_ENTER_SYM, CMD_ENTER_PROG: ok = 1'b1;
      CMD_PROG: ok = prog_mode;
      CMD_SYM:  ok = !prog_mode;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/packet_deframer_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags expiry after TIMEOUT_CYCLES.
module pkt_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic n_btn_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CNT_W-1:0] r_count;
  logic             w_hit;

  // A clear on the expiry cycle wins, so a byte arriving just in time is never timed out.
  assign w_hit = (TIMEOUT_CYCLES != 0) && i_enable && !i_clear && (r_count == CNT_W'(LAST));
  assign o_expired = w_hit;

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst)
      r_count <= '0;
    else if (i_clear || !i_enable || w_hit)
      r_count <= '0;
    else
      r_count <= r_count + 1'b1;
  end

endmodule

// File: rtl/packet_deframer.sv
// Byte-stream packet deframer: finds the header, decodes the command, buffers the payload,
// verifies the XOR trailer and hands complete packets to the consumer on a valid/ready handshake.
module packet_deframer
  import pkt_pkg::*;
#(
  parameter int MAX_PAYLD_BYTES = 7,
  parameter int PROG_LEN        = 7,
  parameter int SYM_LEN         = 5,
  parameter int TIMEOUT_CYCLES  = 100000,
  localparam int LEN_W          = $clog2(MAX_PAYLD_BYTES + 1)
) (
  input  logic                         i_clk,
  input  logic                         n_btn_rst,
  input  logic                         i_rx_stb,
  input  logic [7:0]                   i_rx_data,
  input  logic                         i_rx_err,
  output logic                         o_pkt_valid,
  input  logic                         i_pkt_ready,
  output logic [7:0]                   o_pkt_cmd,
  output logic [LEN_W-1:0]             o_pkt_len,
  output logic [8*MAX_PAYLD_BYTES-1:0] o_payload,
  output logic                         o_is_prog_mode,
  output logic                         o_err_stb,
  output logic [2:0]                   o_err_code
);

  state_e                       r_state;
  logic [7:0]                   r_cmd;
  logic [7:0]                   r_csum;
  logic [LEN_W-1:0]             r_len;
  logic [LEN_W-1:0]             r_idx;
  logic [8*MAX_PAYLD_BYTES-1:0] r_buf;
  logic                         r_pkt_valid;
  logic [7:0]                   r_pkt_cmd;
  logic [LEN_W-1:0]             r_pkt_len;
  logic                         r_prog_mode;
  logic                         r_err_stb;
  logic [2:0]                   r_err_code;

  logic [LEN_W-1:0] w_len;
  logic             w_legal;
  logic             w_in_pkt;
  logic             w_expired;
  logic             w_header;

  assign w_len    = LEN_W'(cmd_len(i_rx_data, PROG_LEN, SYM_LEN));
  assign w_legal  = cmd_legal(i_rx_data, r_prog_mode);
  assign w_in_pkt = (r_state == CMD) || (r_state == PAYLOAD) || (r_state == CHECKSUM);
  assign w_header = i_rx_stb && !i_rx_err && (i_rx_data == HEADER_BYTE);

  pkt_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .n_btn_rst(n_btn_rst),
    .i_clear  (i_rx_stb),
    .i_enable (w_in_pkt),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_csum      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_buf       <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_cmd   <= '0;
      r_pkt_len   <= '0;
      r_prog_mode <= 1'b1;
      r_err_stb   <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_err_stb <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_header) begin
            r_state <= CMD;
            r_buf   <= '0;
          end
        end

        CMD, PAYLOAD, CHECKSUM: begin
          if (i_rx_stb) begin
            if (i_rx_err) begin
              r_state    <= IDLE;
              r_err_stb  <= 1'b1;
              r_err_code <= ERR_RX;
            end else begin
              case (r_state)
                CMD: begin
                  if (!w_legal) begin
                    r_state    <= IDLE;
                    r_err_stb  <= 1'b1;
                    r_err_code <= ERR_BAD_CMD;
                  end else begin
                    r_cmd   <= i_rx_data;
                    r_csum  <= i_rx_data;
                    r_len   <= w_len;
                    r_idx   <= '0;
                    r_state <= (w_len != '0) ? PAYLOAD : CHECKSUM;
                  end
                end
                PAYLOAD: begin
                  for (int k = 0; k < MAX_PAYLD_BYTES; k++)
                    if (r_idx == LEN_W'(k))
                      r_buf[8*k +: 8] <= i_rx_data;
                  r_csum <= r_csum ^ i_rx_data;
                  if (r_idx == r_len - LEN_W'(1))
                    r_state <= CHECKSUM;
                  else
                    r_idx <= r_idx + LEN_W'(1);
                end
                CHECKSUM: begin
                  if (i_rx_data != r_csum) begin
                    r_state    <= IDLE;
                    r_err_stb  <= 1'b1;
                    r_err_code <= ERR_CSUM;
                  end else if (r_cmd == CMD_PROG || r_cmd == CMD_SYM) begin
                    r_state     <= OUTPUT;
                    r_pkt_valid <= 1'b1;
                    r_pkt_cmd   <= r_cmd;
                    r_pkt_len   <= r_len;
                  end else begin
                    // Mode-control and NOP packets are consumed here and never reach the consumer.
                    r_state <= IDLE;
                    if (r_cmd == CMD_ENTER_SYM)
                      r_prog_mode <= 1'b0;
                    else if (r_cmd == CMD_ENTER_PROG)
                      r_prog_mode <= 1'b1;
                  end
                end
                default: r_state <= IDLE;
              endcase
            end
          end else if (w_expired) begin
            r_state    <= IDLE;
            r_err_stb  <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end

        OUTPUT: begin
          if (i_rx_stb && !i_pkt_ready) begin
            r_err_stb  <= 1'b1;
            r_err_code <= ERR_OVERFLOW;
          end else if (i_pkt_ready) begin
            // On acceptance a simultaneous byte is treated exactly as IDLE would treat it.
            r_pkt_valid <= 1'b0;
            if (w_header) begin
              r_state <= CMD;
              r_buf   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pkt_valid    = r_pkt_valid;
  assign o_pkt_cmd      = r_pkt_cmd;
  assign o_pkt_len      = r_pkt_len;
  assign o_payload      = r_buf;
  assign o_is_prog_mode = r_prog_mode;
  assign o_err_stb      = r_err_stb;
  assign o_err_code     = r_err_code;

endmodule

// File: tb/tb_packet_deframer.sv
// Directed scoreboard bench for packet_deframer: stimulus queues expected packets/errors, a negedge monitor checks them.
module tb_packet_deframer;

  localparam int MAXB  = 7;
  localparam int LEN_W = $clog2(MAXB + 1);
  localparam int TMO   = 16;

  logic             clk;
  logic             rstN;
  logic             rxStb;
  logic [7:0]       rxData;
  logic             rxErr;
  logic             pktValid;
  logic             pktReady;
  logic [7:0]       pktCmd;
  logic [LEN_W-1:0] pktLen;
  logic [8*MAXB-1:0] payload;
  logic             isProgMode;
  logic             errStb;
  logic [2:0]       errCode;

  typedef struct {
    logic [7:0]  cmd;
    logic [2:0]  len;
    logic [55:0] data;
    int          due;
  } pktExp_t;

  typedef struct {
    logic [2:0] code;
    int         due;
  } errExp_t;

  pktExp_t pktQ[$];
  errExp_t errQ[$];

  int compared = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int lastStbCycle = 0;

  packet_deframer #(
    .MAX_PAYLD_BYTES(MAXB),
    .PROG_LEN       (7),
    .SYM_LEN        (5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk         (clk),
    .n_btn_rst     (rstN),
    .i_rx_stb      (rxStb),
    .i_rx_data     (rxData),
    .i_rx_err      (rxErr),
    .o_pkt_valid   (pktValid),
    .i_pkt_ready   (pktReady),
    .o_pkt_cmd     (pktCmd),
    .o_pkt_len     (pktLen),
    .o_payload     (payload),
    .o_is_prog_mode(isProgMode),
    .o_err_stb     (errStb),
    .o_err_code    (errCode)
  );

  // Free-running 10 ns clock plus a cycle counter used to time-stamp expected events.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point: every check, from stimulus or monitor, funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one received byte as a single-cycle strobe and records the cycle it was sampled on.
  task automatic applyStimulus(input logic [7:0] data, input logic err = 1'b0);
    rxStb  = 1'b1;
    rxData = data;
    rxErr  = err;
    @(posedge clk);
    #1;
    rxStb  = 1'b0;
    rxErr  = 1'b0;
    lastStbCycle = cycleCount;
  endtask

  task automatic pushPkt(input logic [7:0] cmd, input logic [2:0] len, input logic [55:0] data, input int due);
    pktExp_t e;
    e.cmd = cmd; e.len = len; e.data = data; e.due = due;
    pktQ.push_back(e);
  endtask

  task automatic pushErr(input logic [2:0] code, input int due);
    errExp_t e;
    e.code = code; e.due = due;
    errQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard whenever the DUT emits a packet or an error.
  always @(negedge clk) begin
    if (rstN) begin
      if (pktValid && pktReady) begin
        if (pktQ.size() == 0) begin
          checkOutput("unexpected packet cmd", {56'd0, pktCmd}, 64'hFFFF);
        end else begin
          pktExp_t e;
          e = pktQ.pop_front();
          checkOutput("packet", {pktCmd, 5'd0, pktLen, payload}, {e.cmd, 5'd0, e.len, e.data});
          if (e.due >= 0)
            checkOutput("packet latency", 64'(cycleCount), 64'(e.due));
        end
      end
      if (errStb) begin
        if (errQ.size() == 0) begin
          checkOutput("unexpected error code", {61'd0, errCode}, 64'hFFFF);
        end else begin
          errExp_t e;
          e = errQ.pop_front();
          checkOutput("error code", {61'd0, errCode}, {61'd0, e.code});
          if (e.due >= 0)
            checkOutput("error timing", 64'(cycleCount), 64'(e.due));
        end
      end
    end
  end

  initial begin
    rstN = 1'b0;
    rxStb = 1'b0;
    rxData = 8'h00;
    rxErr = 1'b0;
    pktReady = 1'b1;

    #23;
    checkOutput("reset outputs",
                {46'd0, pktValid, pktCmd, pktLen, errCode, errStb, isProgMode},
                {46'd0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1});
    checkOutput("reset payload", {8'd0, payload}, 64'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    idleCycles(2);

    // Full PROG packet, checksum 0x01.
    applyStimulus(8'hF5); applyStimulus(8'h01);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    applyStimulus(8'h55); applyStimulus(8'h66); applyStimulus(8'h77);
    applyStimulus(8'h01);
    pushPkt(8'h01, 3'd7, 56'h77665544332211, lastStbCycle);
    idleCycles(3);

    // Enter symbol mode; nothing emitted.
    applyStimulus(8'hF5); applyStimulus(8'h02); applyStimulus(8'h02);
    checkOutput("mode after ENTER_SYM", {63'd0, isProgMode}, 64'd0);
    idleCycles(2);

    // SYM packet, checksum 0xED.
    applyStimulus(8'hF5); applyStimulus(8'h03);
    applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC); applyStimulus(8'hDD); applyStimulus(8'hEE);
    applyStimulus(8'hED);
    pushPkt(8'h03, 3'd5, 56'h0000EEDDCCBBAA, lastStbCycle);
    idleCycles(3);

    // PROG in symbol mode is a bad command; trailing bytes are ignored.
    applyStimulus(8'hF5); applyStimulus(8'h01);
    pushErr(3'd2, lastStbCycle);
    applyStimulus(8'h01); applyStimulus(8'h11); applyStimulus(8'h22);
    idleCycles(2);

    // Wrong checksum (correct would be 0x02), then a good packet with checksum 0x13.
    applyStimulus(8'hF5); applyStimulus(8'h03);
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04); applyStimulus(8'h05);
    applyStimulus(8'h55);
    pushErr(3'd3, lastStbCycle);
    idleCycles(2);
    applyStimulus(8'hF5); applyStimulus(8'h03);
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h30); applyStimulus(8'h40); applyStimulus(8'h50);
    applyStimulus(8'h13);
    pushPkt(8'h03, 3'd5, 56'h00005040302010, lastStbCycle);
    idleCycles(3);

    // Receive error inside a packet.
    applyStimulus(8'hF5); applyStimulus(8'h03); applyStimulus(8'h09, 1'b1);
    pushErr(3'd1, lastStbCycle);
    idleCycles(2);

    // Timeout: silence after a payload byte.
    applyStimulus(8'hF5); applyStimulus(8'h03); applyStimulus(8'h01);
    pushErr(3'd4, lastStbCycle + TMO);
    idleCycles(TMO + 4);

    // Hold ready low while a packet is pending: bytes overflow, packet is kept.
    pktReady = 1'b0;
    applyStimulus(8'hF5); applyStimulus(8'h03);
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04); applyStimulus(8'h05);
    applyStimulus(8'h02);
    pushPkt(8'h03, 3'd5, 56'h00000504030201, -1);
    idleCycles(2);
    applyStimulus(8'h11); pushErr(3'd5, lastStbCycle);
    applyStimulus(8'h22); pushErr(3'd5, lastStbCycle);
    applyStimulus(8'h33); pushErr(3'd5, lastStbCycle);
    idleCycles(2);
    checkOutput("held valid", {63'd0, pktValid}, 64'd1);
    checkOutput("held payload", {8'd0, payload}, {8'd0, 56'h00000504030201});

    // Accept together with a header byte: FSM goes straight to CMD, so ENTER_PROG completes.
    pktReady = 1'b1;
    #3;
    applyStimulus(8'hF5);
    applyStimulus(8'h04); applyStimulus(8'h04);
    checkOutput("mode after ENTER_PROG", {63'd0, isProgMode}, 64'd1);
    checkOutput("valid dropped", {63'd0, pktValid}, 64'd0);
    idleCycles(2);

    // Reset in the middle of a payload.
    applyStimulus(8'hF5); applyStimulus(8'h01); applyStimulus(8'h11); applyStimulus(8'h22);
    rstN = 1'b0;
    #2;
    checkOutput("mid-packet reset outputs",
                {46'd0, pktValid, pktCmd, pktLen, errCode, errStb, isProgMode},
                {46'd0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1});
    checkOutput("mid-packet reset payload", {8'd0, payload}, 64'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    idleCycles(2);

    // Decoder works normally after reset.
    applyStimulus(8'hF5); applyStimulus(8'h01);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    applyStimulus(8'h55); applyStimulus(8'h66); applyStimulus(8'h77);
    applyStimulus(8'h01);
    pushPkt(8'h01, 3'd7, 56'h77665544332211, lastStbCycle);
    idleCycles(4);

    checkOutput("pending packets", 64'(pktQ.size()), 64'd0);
    checkOutput("pending errors", 64'(errQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
